stage_sequencer: RTL and testbench
==================================

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: leave IDLE and begin fetching.
REQ-005 The block SHALL have port opcode, input, 6 bits: instruction opcode, valid during DECODE.
REQ-006 The block SHALL have port funct, input, 6 bits: R-type function field, valid during DECODE.
REQ-007 The block SHALL have port ZERO, input, 1 bit: ALU zero flag, registered by the ALU on the EXECUTE edge.
REQ-008 The block SHALL have port stage, output, 3 bits: current stage code, driven to the ALU.
REQ-009 The block SHALL have port alu_op, output, 2 bits: ALU operation class.
REQ-010 The block SHALL have port alu_funct, output, 6 bits: function field forwarded to the ALU.
REQ-011 The block SHALL have port ALU_Src, output, 1 bit: 1 selects sign_extend as the ALU B operand.
REQ-012 The block SHALL have ports pc_write, reg_write, mem_read, mem_write and branch_taken, outputs, 1 bit each: single-cycle strobes.
REQ-013 The block SHALL have ports busy and halted, outputs, 1 bit each: status flags.
REQ-014 The block SHALL have port instr_count, output, CNT_W bits: count of retired instructions.

Function
REQ-015 The block SHALL implement states IDLE, FETCH (stage=0), DECODE (1), EXECUTE (2), MEM (3), WB (4) and HALT (7); IDLE drives stage=5.
REQ-016 In IDLE, start=1 SHALL move the block to FETCH on the next edge; otherwise it SHALL remain in IDLE.
REQ-017 FETCH SHALL assert pc_write for exactly its one cycle and then go to DECODE.
REQ-018 DECODE SHALL latch opcode and funct into internal registers, which hold until the next DECODE.
- alu_op, alu_funct and ALU_Src SHALL be driven from these registers.
REQ-019 Decode SHALL be as follows:
- 000000 (R-type): alu_op=00, ALU_Src=0, path EX->WB.
- 001000 (ADDI): alu_op=11, ALU_Src=1, path EX->WB.
- 100011 (LW): alu_op=11, ALU_Src=1, path EX->MEM->WB.
- 101011 (SW): alu_op=11, ALU_Src=1, path EX->MEM.
- 000100 (BEQ) and 000101 (BNE): alu_op=01, ALU_Src=0, path EX->MEM.
REQ-020 Opcode 111111, or any opcode not listed in REQ-019, SHALL go from DECODE to HALT.
- An unlisted opcode SHALL NOT retire.
REQ-021 An R-type funct outside {100100, 100101, 100000, 100010, 011000, 011010} SHALL go to HALT.
REQ-022 EXECUTE SHALL last exactly one cycle.
- Exception: funct 011010 (DIV) SHALL hold stage=2 for 4 cycles total.
- Exception: funct 011000 (MUL) SHALL hold stage=2 for 2 cycles total.
REQ-023 For branches, the block SHALL sample ZERO during the MEM cycle, i.e. after the ALU's registered update.
- branch_taken SHALL be 1 for that one cycle when (BEQ and ZERO=1) or (BNE and ZERO=0).
REQ-024 mem_read SHALL be asserted for one cycle in MEM for LW; mem_write SHALL be asserted for one cycle in MEM for SW.
REQ-025 reg_write SHALL be asserted for one cycle in WB.
REQ-026 The last state of each instruction path SHALL increment instr_count by 1 (wrapping modulo 2^CNT_W) and then go to FETCH.
REQ-027 HALT SHALL assert halted=1 and drive all strobes to 0.
- HALT SHALL be exited only by reset; start SHALL be ignored in HALT.
REQ-028 busy SHALL be 1 in every state except IDLE and HALT.
REQ-029 All outputs SHALL be registered or decoded from registered state only, with no combinational path from opcode or funct to any output.
REQ-030 start SHALL be ignored outside IDLE.

Reset
REQ-031 reset_n=0 SHALL immediately, without waiting for a clock edge, force the following, including in mid-instruction and in HALT:
- state IDLE, stage=5;
- alu_op=00, alu_funct=0, ALU_Src=0;
- all strobes 0;
- busy=0, halted=0, instr_count=0.
REQ-032 The first start SHALL be accepted on the first rising edge on which reset_n=1.

Verification
REQ-033 The bench SHALL apply start and then ADD (opcode 0, funct 100000) and check stage sequence 0,1,2,4, with reg_write in the 4th cycle and instr_count=1.
REQ-034 The bench SHALL apply LW and then SW and check stages 0,1,2,3,4 then 0,1,2,3, with mem_read then mem_write in the stage-3 cycles, reg_write only for LW, and instr_count=2.
REQ-035 The bench SHALL run BEQ with ZERO=1 and then BNE with ZERO=1, and check branch_taken=1 then 0.
REQ-036 The bench SHALL run DIV and check stage=2 for exactly 4 cycles; MUL SHALL give exactly 2 cycles.
REQ-037 The bench SHALL apply opcode 111111 and check halted=1, busy=0 and instr_count unchanged, with start ignored; asserting reset_n=0 SHALL then return the block to IDLE.
REQ-038 The bench SHALL assert reset_n=0 in the middle of EXECUTE and check all outputs at their reset values with no clock edge; it SHALL also preload instr_count=0xFFFF and retire one instruction, expecting 0x0000.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB,
// drives per-stage strobes and ALU control, and counts retired instructions.
module stage_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             ZERO,
  output logic [2:0]       stage,
  output logic [1:0]       alu_op,
  output logic [5:0]       alu_funct,
  output logic             ALU_Src,
  output logic             pc_write,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch_taken,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IDLE   = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] FN_MUL  = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  state_t           state_q, state_d;
  logic [5:0]       op_q, funct_q;
  logic [1:0]       ex_cnt_q, ex_cnt_d;
  logic [1:0]       ex_last;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch_en;
  logic             is_r_q, is_br_q, uses_mem_q;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == 6'b100100) || (f == 6'b100101) || (f == 6'b100000) ||
           (f == 6'b100010) || (f == FN_MUL) || (f == FN_DIV);
  endfunction

  assign is_r_q     = (op_q == OP_R);
  assign is_br_q    = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign uses_mem_q = is_br_q || (op_q == OP_LW) || (op_q == OP_SW);

  // Extra EXECUTE cycles beyond the first, for the multi-cycle ALU ops.
  assign ex_last = (is_r_q && funct_q == FN_DIV) ? 2'd3 :
                   (is_r_q && funct_q == FN_MUL) ? 2'd1 : 2'd0;

  always_comb begin
    state_d  = state_q;
    ex_cnt_d = ex_cnt_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        latch_en = 1'b1;
        case (opcode)
          OP_R:                                   state_d = funct_ok(funct) ? S_EXEC : S_HALT;
          OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE:  state_d = S_EXEC;
          default:                                state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        if (ex_cnt_q == ex_last) begin
          ex_cnt_d = 2'd0;
          state_d  = uses_mem_q ? S_MEM : S_WB;
        end else begin
          ex_cnt_d = ex_cnt_q + 2'd1;
        end
      end
      S_MEM: begin
        if (op_q == OP_LW) begin
          state_d = S_WB;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= 6'd0;
      funct_q  <= 6'd0;
      ex_cnt_q <= 2'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ex_cnt_q <= ex_cnt_d;
      cnt_q    <= cnt_d;
      if (latch_en) begin
        op_q    <= opcode;
        funct_q <= funct;
      end
    end
  end

  // ZERO comes straight from the ALU's own register, so using it here keeps
  // every output a function of registered state.
  assign stage        = state_q;
  assign pc_write     = (state_q == S_FETCH);
  assign reg_write    = (state_q == S_WB);
  assign mem_read     = (state_q == S_MEM) && (op_q == OP_LW);
  assign mem_write    = (state_q == S_MEM) && (op_q == OP_SW);
  assign branch_taken = (state_q == S_MEM) &&
                        (((op_q == OP_BEQ) && ZERO) || ((op_q == OP_BNE) && !ZERO));
  assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted       = (state_q == S_HALT);
  assign instr_count  = cnt_q;
  assign alu_funct    = funct_q;

  always_comb begin
    alu_op  = 2'b00;
    ALU_Src = 1'b0;
    case (op_q)
      OP_ADDI, OP_LW, OP_SW: begin
        alu_op  = 2'b11;
        ALU_Src = 1'b1;
      end
      OP_BEQ, OP_BNE: alu_op = 2'b01;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboarded random bench for stage_sequencer: a driver feeds instructions and
// pushes expected per-cycle traces; a monitor rebuilds traces from the DUT and compares.
module tb_stage_sequencer;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_HLT  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_MUL  = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        ZERO = 1'b0;
  logic [2:0]  stage;
  logic [1:0]  alu_op;
  logic [5:0]  alu_funct;
  logic        ALU_Src, pc_write, reg_write, mem_read, mem_write, branch_taken;
  logic        busy, halted;
  logic [15:0] instr_count;

  stage_sequencer #(.CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode), .funct(funct),
    .ZERO(ZERO), .stage(stage), .alu_op(alu_op), .alu_funct(alu_funct), .ALU_Src(ALU_Src),
    .pc_write(pc_write), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch_taken(branch_taken), .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] trace;
    int          len;
    logic [15:0] cnt;
    logic [1:0]  aop;
    logic        src;
    logic [5:0]  afn;
    bit          halt;
    logic [5:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_cnt = 16'd0;
  bit          mon_en = 1'b0;
  logic [5:0]  fset[6] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b011000, 6'b011010};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t add(input exp_t e, input logic [7:0] b);
    e.trace = {e.trace[55:0], b};
    e.len++;
    return e;
  endfunction

  // Reference: per-cycle {stage, pc_write, reg_write, mem_read, mem_write, branch_taken}.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input logic [15:0] cnt0);
    exp_t e;
    bit is_r, is_br, known, ok;
    int nex;
    is_r  = (op == OP_R);
    is_br = (op == OP_BEQ) || (op == OP_BNE);
    known = is_r || is_br || op == OP_ADDI || op == OP_LW || op == OP_SW;
    ok    = known && (!is_r || (fn inside {6'b100100, 6'b100101, 6'b100000,
                                           6'b100010, 6'b011000, 6'b011010}));
    e.trace = '0; e.len = 0; e.cnt = cnt0; e.halt = !ok; e.op = op;
    e.aop = is_r ? 2'b00 : (is_br ? 2'b01 : 2'b11);
    e.src = !(is_r || is_br);
    e.afn = fn;
    e = add(e, {3'd0, 5'b10000});
    e = add(e, {3'd1, 5'b00000});
    if (ok) begin
      nex = (is_r && fn == FN_DIV) ? 4 : ((is_r && fn == FN_MUL) ? 2 : 1);
      for (int i = 0; i < nex; i++) e = add(e, {3'd2, 5'b00000});
      if (is_br || op == OP_LW || op == OP_SW)
        e = add(e, {3'd3, 1'b0, 1'b0, (op == OP_LW), (op == OP_SW),
                    ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z)});
      if (is_r || op == OP_ADDI || op == OP_LW)
        e = add(e, {3'd4, 1'b0, 1'b1, 3'b000});
      e.cnt = cnt0 + 16'd1;
    end
    return e;
  endfunction

  // Monitor
  logic [63:0] tr = '0;
  int          tl = 0;
  logic [8:0]  cap_alu = '0;

  task automatic finalize(input bit at_halt);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_underflow actual=empty required=pending_entry at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      $display("txn op=%b len=%0d trace=%0h cnt=%0h halted=%0b", e.op, tl, tr, instr_count, at_halt);
      check("trace", tr, e.trace);
      check("trace_len", 64'(tl), 64'(e.len));
      check("instr_count", {48'd0, instr_count}, {48'd0, e.cnt});
      check("end_kind", {63'd0, at_halt}, {63'd0, e.halt});
      if (!e.halt) check("alu_ctrl", {55'd0, cap_alu}, {55'd0, e.aop, e.src, e.afn});
    end
    tr = '0;
    tl = 0;
  endtask

  always @(negedge clock) begin
    if (!reset_n || !mon_en) begin
      tr = '0;
      tl = 0;
    end else if (busy) begin
      if (stage == 3'd0 && tl > 0) finalize(1'b0);
      if (stage == 3'd2) cap_alu = {alu_op, ALU_Src, alu_funct};
      tr = {tr[55:0], stage, pc_write, reg_write, mem_read, mem_write, branch_taken};
      tl++;
    end else if (halted && tl > 0) begin
      finalize(1'b1);
    end
  end

  // Driver: present the instruction during DECODE, scribble on inputs elsewhere.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t e;
    int n = 0;
    do begin
      @(negedge clock);
      n++;
      if (stage !== 3'd0 && stage !== 3'd1) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        start  = 1'($urandom);
      end
    end while (stage !== 3'd0 && n < 40);
    if (stage !== 3'd0) begin
      checks++; failures++;
      $display("FAIL drv_timeout actual_stage=%0d required_stage=0", stage);
    end
    opcode = op;
    funct  = fn;
    ZERO   = z;
    e = model(op, fn, z, model_cnt);
    model_cnt = e.cnt;
    sb_q.push_back(e);
  endtask

  task automatic wait_halt(input string name);
    int n = 0;
    while (!halted && n < 60) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!halted) begin
      failures++;
      $display("FAIL %s actual_halted=0 required_halted=1", name);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_outs"},
          {45'd0, stage, alu_op, alu_funct, ALU_Src, pc_write, reg_write, mem_read,
           mem_write, branch_taken, busy, halted},
          {45'd0, 3'd5, 2'b00, 6'd0, 1'b0, 5'b00000, 1'b0, 1'b0});
    check({name, "_count"}, {48'd0, instr_count}, 64'd0);
  endtask

  initial begin
    logic [5:0] rop;
    logic [5:0] rfn;
    int         n;
    logic [5:0] ops[6] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};

    #2 reset_n = 1'b0;
    #1 check_reset("por");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_hold", {61'd0, stage}, 64'd5);

    mon_en = 1'b1;
    start  = 1'b1;
    issue(OP_R, FN_ADD, 1'b0);
    issue(OP_LW, 6'h15, 1'b0);
    issue(OP_SW, 6'h2a, 1'b1);
    issue(OP_BEQ, 6'h00, 1'b1);
    issue(OP_BNE, 6'h00, 1'b1);
    issue(OP_R, FN_DIV, 1'b0);
    issue(OP_R, FN_MUL, 1'b0);
    for (int i = 0; i < 60; i++) begin
      rop = ops[$urandom_range(0, 5)];
      rfn = (rop == OP_R) ? fset[$urandom_range(0, 5)] : 6'($urandom);
      issue(rop, rfn, 1'($urandom));
    end
    issue(OP_HLT, 6'h00, 1'b0);
    wait_halt("halt_entry");
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    check("halt_flags", {62'd0, halted, busy}, 64'b10);
    check("halt_count", {48'd0, instr_count}, {48'd0, model_cnt});
    start = 1'b1;
    repeat (5) @(negedge clock);
    check("halt_ignores_start", {60'd0, halted, stage}, {60'd0, 1'b1, 3'd7});

    mon_en = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset("halt_reset");

    @(negedge clock);
    reset_n = 1'b1;
    start   = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    opcode = OP_R;
    funct  = FN_DIV;
    n = 0;
    while (stage !== 3'd2 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("reach_exec", {61'd0, stage}, 64'd2);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset("exec_reset");

    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    force dut.cnt_q = 16'hFFFF;
    #1 release dut.cnt_q;
    #1 check("preload", {48'd0, instr_count}, 64'hFFFF);
    model_cnt = 16'hFFFF;
    mon_en = 1'b1;
    @(negedge clock);
    start = 1'b1;
    issue(OP_R, FN_ADD, 1'b0);
    issue(OP_HLT, 6'h00, 1'b0);
    wait_halt("halt_after_wrap");
    check("sb_drain_wrap", 64'(sb_q.size()), 64'd0);
    check("wrap_count", {48'd0, instr_count}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
